mem_loader: RTL

- Host-side writer for the CPU's memory path; the counterpart of the sequential display-mode reader.
- Accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes the words to consecutive word addresses of instruction/data memory while holding the CPU.
- Verifies an XOR checksum, then releases the CPU or flags an error.

---
 rtl/mem_loader_pkg.sv | 22 ++
 rtl/mem_loader_if.sv | 21 ++
 rtl/mem_loader_byte_packer.sv | 40 ++++
 rtl/mem_loader.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
// Shared state encoding and frame geometry for the memory loader.
package mem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_DATA  = 3'd2,
        S_WR    = 3'd3,
        S_CHK   = 3'd4,
        S_DONE  = 3'd5,
        S_ERROR = 3'd6
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    // States that can accept a new load request.
    function automatic logic is_restartable(input state_t s);
        return (s == S_IDLE) || (s == S_DONE) || (s == S_ERROR);
    endfunction

endpackage

// File: rtl/mem_loader_if.sv
// Byte-stream handshake plus memory write port of the loader.
interface mem_loader_if;

    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/mem_loader_byte_packer.sv
// Big-endian byte-to-word shifter with running XOR checksum.
// word_ready_o/word_o are combinational on the 4th shifted byte; no backpressure of its own.
module byte_packer
    import mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic        word_ready_o,
    output logic [31:0] word_o,
    output logic [7:0]  checksum_o
);

    logic [23:0] word_q;
    logic [1:0]  idx_q;
    logic [7:0]  chk_q;

    assign word_ready_o = shift_i && (idx_q == 2'(BYTES_PER_WORD - 1));
    assign word_o       = {word_q, byte_i};
    assign checksum_o   = chk_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q <= '0;
            idx_q  <= '0;
            chk_q  <= '0;
        end else if (clr_i) begin
            word_q <= '0;
            idx_q  <= '0;
            chk_q  <= '0;
        end else if (shift_i) begin
            word_q <= {word_q[15:0], byte_i};
            idx_q  <= idx_q + 2'd1;
            chk_q  <= chk_q ^ byte_i;
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Framed byte stream -> consecutive 32-bit memory writes, holding the CPU until the checksum matches.
// Write strobe one cycle after the last byte of a word; done/error one cycle after the checksum byte.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int          MAX_WORDS = 256,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    mem_loader_if.slave      bus,
    output logic             cpu_hold,
    output logic             load_done,
    output logic             load_error,
    output logic [CNT_W-1:0] words_written
);

    state_t           state_q;
    logic             byte_ready_q;
    logic             mem_we_q;
    logic             cpu_hold_q;
    logic             done_q;
    logic             err_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [CNT_W-1:0] ww_q;
    logic [CNT_W-1:0] n_q;
    logic [7:0]       n_hi_q;
    logic             hdr_idx_q;

    logic        fire;
    logic        restart;
    logic        word_ready;
    logic [31:0] word;
    logic [7:0]  checksum;
    logic [15:0] hdr_count;
    logic        hdr_bad;
    logic        last_word;

    assign fire      = bus.byte_valid && byte_ready_q;
    assign restart   = start && is_restartable(state_q);
    assign hdr_count = {n_hi_q, bus.byte_in};
    assign hdr_bad   = (hdr_count == 16'd0) || (32'(hdr_count) > 32'(MAX_WORDS));
    assign last_word = (ww_q + CNT_W'(1)) == n_q;

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (restart),
        .shift_i      (fire && (state_q == S_DATA)),
        .byte_i       (bus.byte_in),
        .word_ready_o (word_ready),
        .word_o       (word),
        .checksum_o   (checksum)
    );

    // byte_ready is registered alongside each state transition so it depends on state only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ww_q         <= '0;
            n_q          <= '0;
            n_hi_q       <= '0;
            hdr_idx_q    <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_q      <= S_HDR;
                        byte_ready_q <= 1'b1;
                        cpu_hold_q   <= 1'b1;
                        done_q       <= 1'b0;
                        err_q        <= 1'b0;
                        ww_q         <= '0;
                        hdr_idx_q    <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (fire) begin
                        if (!hdr_idx_q) begin
                            n_hi_q    <= bus.byte_in;
                            hdr_idx_q <= 1'b1;
                        end else begin
                            n_q <= CNT_W'(hdr_count);
                            if (hdr_bad) begin
                                state_q      <= S_ERROR;
                                byte_ready_q <= 1'b0;
                                err_q        <= 1'b1;
                            end else begin
                                state_q <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (word_ready) begin
                        state_q      <= S_WR;
                        byte_ready_q <= 1'b0;
                        mem_we_q     <= 1'b1;
                        addr_q       <= BASE_ADDR + 32'(ww_q);
                        wdata_q      <= word;
                    end
                end
                S_WR: begin
                    ww_q         <= ww_q + CNT_W'(1);
                    byte_ready_q <= 1'b1;
                    state_q      <= last_word ? S_CHK : S_DATA;
                end
                S_CHK: begin
                    if (fire) begin
                        byte_ready_q <= 1'b0;
                        if (bus.byte_in == checksum) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= S_ERROR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    byte_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign cpu_hold       = cpu_hold_q;
    assign load_done      = done_q;
    assign load_error     = err_q;
    assign words_written  = ww_q;

endmodule
